// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped 8N1 UART transmitter that snoops the core's data-side store
// bus. Byte stores to TXDATA are queued in a small circular FIFO and shifted
// out LSB first on tx. Loads from STATUS return {29'b0, overflow, full, empty}.
//
// Register map (full 32-bit address match only):
//   BASE_ADDR + 0 : TXDATA  write -> push WriteData[7:0] (dropped when full,
//                           which sets the sticky overflow flag)
//   BASE_ADDR + 4 : STATUS  read  -> {29'b0, overflow, full, empty}
//                           write -> WriteData[0]=1 clears overflow
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   DataAdr    core data address
//   WriteData  core store data (bits [7:0] used for TXDATA, bit 0 for STATUS)
//   MemWrite   core store strobe
//   sel        combinational, high when DataAdr hits TXDATA or STATUS
//   rd_data    combinational, STATUS word when DataAdr hits STATUS, else 0
//   tx         registered serial output, idle high
//   busy       registered, high while a frame is in flight or bytes are queued
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line high; pops the FIFO head when the FIFO is non-empty
//   ST_START | start bit (low) for CLKS_PER_BIT cycles
//   ST_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
//   ST_STOP  | stop bit (high) for CLKS_PER_BIT cycles
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CW-1:0] BAUD_LAST   = CW'(CLKS_PER_BIT - 1);
    // Pointers that differ only in their MSB mean the FIFO is full.
    localparam logic [PW-1:0] FULL_XOR    = PW'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("mmio_uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mmio_uart_tx: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr_next;
    logic [PW-1:0]   rd_ptr_next;
    logic            overflow;

    logic            hit_data;
    logic            hit_status;
    logic            empty;
    logic            full;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            ovf_clear;
    logic            baud_tc;
    logic            fsm_active_next;

    // Upper store-data bits carry nothing for this peripheral.
    logic            unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    // -----------------------------------------------------------------------
    // Address decode, status readback and FIFO control
    // -----------------------------------------------------------------------
    always_comb begin
        hit_data   = (DataAdr == BASE_ADDR);
        hit_status = (DataAdr == STATUS_ADDR);
        sel        = hit_data || hit_status;

        empty = (wr_ptr == rd_ptr);
        full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);

        rd_data = 32'b0;
        if (hit_status) begin
            rd_data = {29'b0, overflow, full, empty};
        end

        push_req  = MemWrite && hit_data;
        // A pop on the same edge does not make room: fullness is judged on
        // the pre-edge pointers.
        push      = push_req && !full;
        ovf_clear = MemWrite && hit_status && WriteData[0];

        // The pop decision also uses the pre-edge empty flag, so a byte
        // pushed into an empty FIFO is popped one edge later.
        pop = (state == ST_IDLE) && !empty;

        wr_ptr_next = push ? (wr_ptr + PW'(1)) : wr_ptr;
        rd_ptr_next = pop  ? (rd_ptr + PW'(1)) : rd_ptr;

        baud_tc = (baud_cnt == BAUD_LAST);

        // Whether the FSM will be outside IDLE after this edge; feeds busy.
        case (state)
            ST_IDLE: fsm_active_next = pop;
            ST_STOP: fsm_active_next = !baud_tc;
            default: fsm_active_next = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO storage and pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Serialiser FSM with registered tx and busy
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            busy <= fsm_active_next || (wr_ptr_next != rd_ptr_next);

            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr[AW-1:0]];
                        baud_cnt <= '0;
                        state    <= ST_START;
                        tx       <= 1'b0;
                    end
                end

                ST_START: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            // shift[1] is the next bit once the register
                            // has shifted right.
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Inputs change while clk is low; outputs are sampled on the falling edge.
// A background line receiver decodes tx into a byte queue and records the
// cycle at which each start bit was first seen.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] DataAdr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        MemWrite = 1'b0;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .sel      (sel),
        .rd_data  (rd_data),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- line receiver ----------------
    logic [7:0] rx_q [$];
    int         st_q [$];
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h0;
    int         mon_ferr = 0;

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_byte   = 8'h0;
                st_q.push_back(cyc);
            end
        end else begin
            mon_cnt = mon_cnt + 1;
            if (mon_cnt >= 5 && mon_cnt <= 33 && ((mon_cnt - 5) % 4) == 0) begin
                mon_byte = {tx, mon_byte[7:1]};
            end else if (mon_cnt == 37) begin
                if (tx !== 1'b1) mon_ferr = mon_ferr + 1;
                rx_q.push_back(mon_byte);
                mon_active = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Call while clk is low; the store is taken at the next rising edge and
    // the task returns on the following falling edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        DataAdr   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && tx === 1'b1) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s: still busy after %0d cycles (busy=%b tx=%b)", name, budget, busy, tx);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_line cyc %0d: tx=%b busy=%b, want 1/0", i, tx, busy);
            end
        end
        DataAdr = BASE + 32'd4;
        #1;
        vectors++;
        if (sel !== 1'b1 || rd_data !== 32'h1) begin
            miscompares++;
            $display("FAIL status_empty: sel=%b rd_data=%h, want 1/00000001", sel, rd_data);
        end
        DataAdr = BASE;
        #1;
        vectors++;
        if (sel !== 1'b1 || rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL sel_txdata: sel=%b rd_data=%h, want 1/00000000", sel, rd_data);
        end
        DataAdr = BASE + 32'd8;
        #1;
        vectors++;
        if (sel !== 1'b0 || rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL sel_base8: sel=%b rd_data=%h, want 0/00000000", sel, rd_data);
        end
        DataAdr = BASE + 32'd5;
        #1;
        vectors++;
        if (sel !== 1'b0 || rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL sel_base5: sel=%b rd_data=%h, want 0/00000000", sel, rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_single_frame;
        logic [7:0] d;
        logic       exp_tx;
        d = 8'hA5;
        rx_q.delete();
        store(BASE, 32'h1234_56A5);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL push_latency: tx=%b busy=%b, want tx=1 busy=1", tx, busy);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 4)       exp_tx = 1'b0;
            else if (i < 36) exp_tx = d[(i - 4) / 4];
            else             exp_tx = 1'b1;
            vectors++;
            if (tx !== exp_tx || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_a5 cyc %0d: tx=%b busy=%b, want tx=%b busy=1", i, tx, busy, exp_tx);
            end
        end
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_end: tx=%b busy=%b, want 1/0", tx, busy);
        end
        vectors++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL frame_rx: got %0d bytes first=%h, want 1 byte a5", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_bad_addr;
        logic [31:0] addrs [3];
        addrs[0] = BASE + 32'd1;
        addrs[1] = BASE + 32'd8;
        addrs[2] = BASE - 32'd4;
        for (int k = 0; k < 3; k++) begin
            DataAdr   = addrs[k];
            WriteData = 32'h0000_0055;
            MemWrite  = 1'b1;
            #1;
            vectors++;
            if (sel !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_addr_sel %h: sel=%b, want 0", addrs[k], sel);
            end
            @(negedge clk);
            MemWrite = 1'b0;
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_addr_push %h: busy=%b, want 0", addrs[k], busy);
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1) begin
                miscompares++;
                $display("FAIL bad_addr_tx cyc %0d: tx=%b, want 1", i, tx);
            end
        end
        DataAdr = BASE + 32'd4;
        #1;
        vectors++;
        if (rd_data !== 32'h1) begin
            miscompares++;
            $display("FAIL bad_addr_status: rd_data=%h, want 00000001", rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        rx_q.delete();
        st_q.delete();
        for (int b = 1; b <= 6; b++) store(BASE, 32'(b));
        DataAdr = BASE + 32'd4;
        #1;
        vectors++;
        if (rd_data !== 32'h6) begin
            miscompares++;
            $display("FAIL overflow_set: rd_data=%h, want 00000006", rd_data);
        end
        store(BASE + 32'd4, 32'h1);
        #1;
        vectors++;
        if (rd_data !== 32'h2) begin
            miscompares++;
            $display("FAIL overflow_clear: rd_data=%h, want 00000002", rd_data);
        end
        wait_idle(400, "overflow_drain");
        vectors++;
        if (rx_q.size() != 5) begin
            miscompares++;
            $display("FAIL overflow_count: got %0d bytes, want 5", rx_q.size());
        end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== 8'(i + 1)) begin
                miscompares++;
                $display("FAIL overflow_byte %0d: got %h, want %h", i, rx_q[i], 8'(i + 1));
            end
        end
        for (int i = 1; i < 5 && i < st_q.size(); i++) begin
            vectors++;
            if (st_q[i] - st_q[i-1] != 10 * CPB + 1) begin
                miscompares++;
                $display("FAIL b2b_period %0d: got %0d cycles, want %0d", i, st_q[i] - st_q[i-1], 10 * CPB + 1);
            end
        end
        DataAdr = BASE + 32'd4;
        #1;
        vectors++;
        if (rd_data !== 32'h1) begin
            miscompares++;
            $display("FAIL overflow_final_status: rd_data=%h, want 00000001", rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_full_pop_same_edge;
        rx_q.delete();
        for (int b = 0; b < 5; b++) store(BASE, 32'h10 + 32'(b + 1));
        // First byte went out at E1 and re-enters IDLE at E41; the pop of the
        // next byte happens at E42, where the FIFO is still full.
        repeat (37) @(negedge clk);
        store(BASE, 32'h99);
        DataAdr = BASE + 32'd4;
        #1;
        vectors++;
        if (rd_data !== 32'h4) begin
            miscompares++;
            $display("FAIL full_pop_status: rd_data=%h, want 00000004", rd_data);
        end
        wait_idle(400, "full_pop_drain");
        vectors++;
        if (rx_q.size() != 5) begin
            miscompares++;
            $display("FAIL full_pop_count: got %0d bytes, want 5", rx_q.size());
        end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== 8'(8'h11 + i)) begin
                miscompares++;
                $display("FAIL full_pop_byte %0d: got %h, want %h", i, rx_q[i], 8'(8'h11 + i));
            end
        end
    endtask

    task automatic test_reset_midframe;
        int lows;
        rx_q.delete();
        store(BASE, 32'h3C);
        store(BASE, 32'hC3);
        repeat (10) @(negedge clk);
        vectors++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_pre: tx=%b busy=%b, want 0/1", tx, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_reset: tx=%b busy=%b, want 1/0", tx, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        DataAdr = BASE + 32'd4;
        #1;
        vectors++;
        if (rd_data !== 32'h1) begin
            miscompares++;
            $display("FAIL midframe_status: rd_data=%h, want 00000001", rd_data);
        end
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        vectors++;
        if (lows != 0 || rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL midframe_quiet: %0d active cycles, %0d bytes, want 0/0", lows, rx_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_bad_addr();
        test_overflow();
        test_full_pop_same_edge();
        test_reset_midframe();
        vectors++;
        if (mon_ferr != 0) begin
            miscompares++;
            $display("FAIL stop_bits: %0d frames without stop bit, want 0", mon_ferr);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the data-side bus of the single-cycle ARM top level, downstream of the core. It snoops the core's store bus (DataAdr, WriteData, MemWrite), captures byte writes to its TX register into a small FIFO, and serialises them 8N1 on a tx line. It also returns a status word for loads to its STATUS address, which the top level muxes into ReadData when sel is high.

Parameters:
BASE_ADDR, 32'hFFFF_0000, word-aligned base address; TXDATA at BASE_ADDR+0, STATUS at BASE_ADDR+4
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535
FIFO_DEPTH, 4, TX FIFO entries; power of 2, minimum 2

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
DataAdr  input  32  core data address (ALU result)
WriteData  input  32  core store data; only bits [7:0] are used for TXDATA
MemWrite  input  1  core store strobe, sampled on rising edge
sel  output  1  combinational; 1 when DataAdr == BASE_ADDR or DataAdr == BASE_ADDR+4
rd_data  output  32  combinational; STATUS word when DataAdr == BASE_ADDR+4, else 0
tx  output  1  serial output, idle high, registered
busy  output  1  registered; 1 when the FSM is not in IDLE or the FIFO is non-empty

Behaviour:
- Reset (sync, takes effect at the rising edge): FIFO empty, pointers 0, overflow=0, FSM=IDLE, baud counter=0, tx=1, busy=0. Reset mid-frame aborts the frame, so tx=1 after that edge and queued bytes are discarded.
- Address decode: full 32-bit equality only. Addresses with DataAdr[1:0]≠0 or any other offset do not hit.
- Push: MemWrite=1 && DataAdr==BASE_ADDR at an edge pushes WriteData[7:0]. If the FIFO is full at that edge, the byte is dropped and overflow is set (sticky). This holds even if a pop occurs on the same edge.
- Overflow clear: MemWrite=1 && DataAdr==BASE_ADDR+4 && WriteData[0]==1 clears overflow. A write to STATUS never pushes.
- STATUS read value: {29'b0, overflow, full, empty}, taken from registered state (pre-edge values).
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers. Pointers wrap modulo 2*FIFO_DEPTH. full when the pointers differ only in the MSB; empty when they are equal.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first), each bit held CLKS_PER_BIT cycles, then shift right. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame timing: a frame is 10*CLKS_PER_BIT cycles. IDLE is occupied for at least 1 cycle between frames, so the back-to-back byte period is 10*CLKS_PER_BIT+1 cycles.
- Latency: push at edge E0 into an empty FIFO with FSM in IDLE gives FSM=START and tx=0 from edge E1.
- Push into empty FIFO: a push and the IDLE pop check on the same edge does not pop, because the pop decision uses the pre-edge empty flag.
- Baud counter: counts 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT). It reaches its terminal count on the last cycle of each bit, which advances the state or bit.
- busy is registered from next-state values, so it is 1 from edge E0 in the latency example above. It drops at the edge that enters IDLE with an empty FIFO.

Test Plan:
- Reset, then idle 50 cycles (CLKS_PER_BIT=4) -> tx=1, busy=0, rd_data at BASE+4 = 32'h1 (empty), sel=1 only for BASE+0 and BASE+4.
- Store 32'h1234_56A5 to BASE+0 -> tx goes low one edge after the write, then emits bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high. Total frame 40 cycles, then busy=0.
- Five consecutive stores 0x01..0x05 (DEPTH=4, CLKS_PER_BIT=4) -> the first byte is popped one edge after its push, so it transmits. With 0x02..0x05 filling the FIFO, a further store is dropped; check STATUS bit2=1 after the overflowing store and verify the received serial byte sequence matches the accepted bytes. Store 1 to BASE+4 -> bit2=0.
- Store to BASE+1, BASE+8 and BASE-4 -> sel=0 for each, no push, tx stays 1.
- Two bytes queued, reset asserted mid-DATA of the first -> tx=1 at the next edge, STATUS=32'h1, no further start bit.
- FIFO full and pop on the same edge as a new push -> the push is dropped, overflow=1, and the FIFO count ends at DEPTH-1.
